arc4_key_sweep: RTL and testbench
=================================

Name: arc4_key_sweep

Overview:
- Parametrised successor to the single-key ARC4 top-level controller.
- Drives one arc4 core through the en/rdy handshake across a strided range of candidate keys.
- After each decryption, scans the length-prefixed plaintext memory for printable bytes (0x20..0x7E).
- Reports the first key that yields fully printable plaintext, or exhaustion. Multiple instances with different KEY_START/KEY_STEP partition a keyspace.

Parameters:
- KEY_W, 24, width of the arc4 key bus.
- KEY_START, 0, first key tried.
- KEY_STEP, 1, increment between candidates (channel count in a multi-instance cracker).
- KEY_LAST, 2**KEY_W-1, highest key that may be tried.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en  in  1  start request; accepted only when rdy=1
- rdy  out  1  high when idle and able to accept en
- abort  in  1  synchronous request to stop the search early
- core_en  out  1  single-cycle start pulse to the arc4 core
- core_rdy  in  1  arc4 core ready
- core_key  out  KEY_W  key presented to the core; held stable while the core is busy
- pt_sel  out  1  high while this block owns the plaintext memory port; top-level muxes pt_addr
- pt_addr  out  8  plaintext read address
- pt_rddata  in  8  plaintext read data, 1-cycle synchronous latency
- done  out  1  high from search end until the next accepted en
- found  out  1  valid when done=1; 1 = printable key found
- key_out  out  KEY_W  found key (0 if not found)
- tries  out  KEY_W  number of keys fully tested in this search

Behaviour:
- Reset (asynchronous, any state, including mid-search):
  - state=IDLE, rdy=1, core_en=0, core_key=KEY_START, pt_sel=0, pt_addr=0, done=0, found=0, key_out=0, tries=0.
  - A core left mid-run is re-handshaken normally on the next en.
- States: IDLE, KICK, WAIT_BUSY, WAIT_DONE, RD_LEN, GET_LEN, RD_BYTE, CHK_BYTE, NEXT, DRAIN, DONE.
- IDLE/DONE, en=1:
  - rdy drops the next cycle; done, found and tries are cleared.
  - core_key is loaded with KEY_START.
  - State goes to KICK.
- KICK: wait for core_rdy=1, then pulse core_en for exactly one cycle and go to WAIT_BUSY.
- WAIT_BUSY: wait for core_rdy=0, then go to WAIT_DONE.
- WAIT_DONE: wait for core_rdy=1, then go to RD_LEN.
- RD_LEN: pt_sel=1, pt_addr=0.
- GET_LEN: latch len=pt_rddata and set i=1.
  - len=0: the message is vacuously printable; treat as found.
- Byte scan, 2 cycles per byte:
  - RD_BYTE drives pt_addr=i.
  - CHK_BYTE tests pt_rddata.
  - Byte outside 0x20..0x7E: go to NEXT (key fails).
  - Byte printable and i=len: key passes.
  - Otherwise increment i and go to RD_BYTE.
- Pass:
  - found=1, key_out=core_key, tries+1.
  - State goes to DONE: done=1, rdy=1, pt_sel=0.
- NEXT:
  - tries+1 and pt_sel=0.
  - If core_key > KEY_LAST-KEY_STEP, the search is exhausted: go to DONE with found=0, key_out=0.
  - Otherwise core_key += KEY_STEP and go to KICK.
  - No wrap-around past KEY_LAST. The comparison is computed without overflow at KEY_W+1 bits.
- abort:
  - In KICK, RD_LEN..NEXT: go to DONE with found=0 next cycle.
  - In WAIT_BUSY/WAIT_DONE: go to DRAIN, which waits for core_rdy=1, then DONE with found=0.
  - Ignored in IDLE/DONE.
  - abort and a pass in the same cycle: the pass wins.
- en while rdy=0 is ignored.
- core_key never changes between core_en and core_rdy returning high.
- tries saturates at all-ones.

Test Plan:
- KEY_START=0, STEP=1; core model yields printable text only for key 0x000003 (len=5, "hello") -> found=1, key_out=0x000003, tries=4, done=1, rdy=1.
- KEY_LAST=7, no printable key -> exactly 8 core_en pulses, then done=1, found=0, key_out=0, tries=8, no 9th pulse.
- KEY_START=1, STEP=4, KEY_LAST=10, match at key 9 -> core_key sequence 1,5,9; found=1, key_out=9, tries=3.
- Plaintext len=0 on first key -> found=1, key_out=KEY_START after a single core run, with no RD_BYTE reads.
- First byte 0x1F on key 0, all bytes 0x7E on key 1 (len=255) -> key 0 rejected after 1 byte read; key 1 accepted after pt_addr sweeps 1..255.
- abort during WAIT_DONE, then rst asserted mid-scan on a fresh run -> first: DRAIN until core_rdy=1, then done=1, found=0. Second: all outputs at reset values immediately, rdy=1.

Source files
------------

// File: rtl/arc4_key_sweep.sv
// Strided ARC4 key search: runs the core once per candidate key and stops on the
// first key whose length-prefixed plaintext is entirely printable ASCII.
module arc4_key_sweep #(
  parameter int unsigned      KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_START = '0,
  parameter logic [KEY_W-1:0] KEY_STEP  = KEY_W'(1),
  parameter logic [KEY_W-1:0] KEY_LAST  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  input  logic             abort,
  output logic             core_en,
  input  logic             core_rdy,
  output logic [KEY_W-1:0] core_key,
  output logic             pt_sel,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata,
  output logic             done,
  output logic             found,
  output logic [KEY_W-1:0] key_out,
  output logic [KEY_W-1:0] tries
);

  typedef enum logic [3:0] {
    IDLE, KICK, WAIT_BUSY, WAIT_DONE, RD_LEN, GET_LEN,
    RD_BYTE, CHK_BYTE, NEXT, DRAIN, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] core_key_q, core_key_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic [KEY_W-1:0] tries_q, tries_d, tries_inc;
  logic [7:0]       len_q, len_d, i_q, i_d;
  logic             found_q, found_d;
  logic [KEY_W:0]   key_nxt;
  logic             byte_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      core_key_q <= KEY_START;
      key_out_q  <= '0;
      tries_q    <= '0;
      len_q      <= '0;
      i_q        <= '0;
      found_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_key_q <= core_key_d;
      key_out_q  <= key_out_d;
      tries_q    <= tries_d;
      len_q      <= len_d;
      i_q        <= i_d;
      found_q    <= found_d;
    end
  end

  // One extra bit so the exhaustion test cannot wrap near the top of the keyspace.
  assign key_nxt   = {1'b0, core_key_q} + {1'b0, KEY_STEP};
  assign tries_inc = (&tries_q) ? tries_q : tries_q + 1'b1;
  assign byte_ok   = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);

  always_comb begin
    state_d    = state_q;
    core_key_d = core_key_q;
    key_out_d  = key_out_q;
    tries_d    = tries_q;
    len_d      = len_q;
    i_d        = i_q;
    found_d    = found_q;
    core_en    = 1'b0;
    pt_sel     = 1'b0;
    pt_addr    = '0;
    unique case (state_q)
      IDLE, DONE: if (en) begin
        state_d    = KICK;
        core_key_d = KEY_START;
        found_d    = 1'b0;
        key_out_d  = '0;
        tries_d    = '0;
      end
      KICK: begin
        if (abort) state_d = DONE;
        else if (core_rdy) begin
          core_en = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (abort)          state_d = DRAIN;
        else if (!core_rdy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (abort)         state_d = DRAIN;
        else if (core_rdy) state_d = RD_LEN;
      end
      // The core must finish before the plaintext port can be handed back.
      DRAIN: if (core_rdy) state_d = DONE;
      RD_LEN: begin
        pt_sel  = 1'b1;
        state_d = abort ? DONE : GET_LEN;
      end
      GET_LEN: begin
        pt_sel = 1'b1;
        len_d  = pt_rddata;
        i_d    = 8'd1;
        if (pt_rddata == 8'd0) begin
          found_d   = 1'b1;
          key_out_d = core_key_q;
          tries_d   = tries_inc;
          state_d   = DONE;
        end else begin
          state_d = abort ? DONE : RD_BYTE;
        end
      end
      RD_BYTE: begin
        pt_sel  = 1'b1;
        pt_addr = i_q;
        state_d = abort ? DONE : CHK_BYTE;
      end
      CHK_BYTE: begin
        pt_sel = 1'b1;
        if (!byte_ok) state_d = abort ? DONE : NEXT;
        else if (i_q == len_q) begin
          found_d   = 1'b1;
          key_out_d = core_key_q;
          tries_d   = tries_inc;
          state_d   = DONE;
        end else if (abort) state_d = DONE;
        else begin
          i_d     = i_q + 8'd1;
          state_d = RD_BYTE;
        end
      end
      NEXT: begin
        tries_d = tries_inc;
        if (abort || key_nxt > {1'b0, KEY_LAST}) state_d = DONE;
        else begin
          core_key_d = key_nxt[KEY_W-1:0];
          state_d    = KICK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy      = (state_q == IDLE) || (state_q == DONE);
  assign done     = (state_q == DONE);
  assign core_key = core_key_q;
  assign found    = found_q;
  assign key_out  = key_out_q;
  assign tries    = tries_q;

endmodule

// File: tb/tb_arc4_key_sweep.sv
// Three sweepers with different key partitions, each driving a behavioural arc4
// core + plaintext RAM; results are checked against a key-by-key reference search.
module tb_arc4_key_sweep;
  localparam int N  = 3;
  localparam int KW = 24;
  localparam int KS [N] = '{0, 1, 0};
  localparam int KP [N] = '{1, 4, 1};
  localparam int KL [N] = '{24'hFFFFFF, 10, 7};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [N-1:0] en = '0;
  logic [N-1:0] abort = '0;

  logic          rdy_v [N], done_v [N], found_v [N], core_en_v [N], pt_sel_v [N];
  logic [KW-1:0] key_v [N], tries_v [N], core_key_v [N];
  logic [7:0]    pt_addr_v [N];
  int md [N], mt [N], sd [N], busy_len [N];
  int st_en [N], st_rd [N], st_maxa [N], st_viol [N], st_gap [N], st_ksum [N];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  // Plaintext a core would leave behind for a key. md 0: "hello" at key mt (mt<0: none),
  // otherwise a random-length message with one non-printable byte; md 1: empty message;
  // md 2: key 0 starts with 0x1F, other keys are 255 bytes of 0x7E.
  function automatic logic [7:0] gen(input int m, input int t, input int s, input int key, input int a);
    int len, badp, sel;
    if (m == 1) return (a == 0) ? 8'd0 : 8'h41;
    if (m == 2) begin
      if (a == 0) return 8'd255;
      return (key == 0) ? 8'h1F : 8'h7E;
    end
    if (key == t) begin
      case (a)
        0: return 8'd5;
        1: return 8'h68;
        2: return 8'h65;
        3: return 8'h6C;
        4: return 8'h6C;
        5: return 8'h6F;
        default: return 8'h00;
      endcase
    end
    len  = 1 + ((key * 7 + s) % 20);
    badp = 1 + ((key * 13 + s) % len);
    sel  = (key + s) % 4;
    if (a == 0) return 8'(len);
    if (a == badp) return (sel == 0) ? 8'h1F : (sel == 1) ? 8'h7F : (sel == 2) ? 8'h00 : 8'hFF;
    return 8'(32 + ((a * 31 + key + s) % 95));
  endfunction

  function automatic bit printable_key(input int g, input int key);
    int len;
    len = int'(gen(md[g], mt[g], sd[g], key, 0));
    for (int a = 1; a <= len; a++) begin
      logic [7:0] b;
      b = gen(md[g], mt[g], sd[g], key, a);
      if (b < 8'h20 || b > 8'h7E) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic ref_run(input int g, output bit f, output int k, output int t);
    longint key;
    key = KS[g];
    f = 0; k = 0; t = 0;
    while (key <= longint'(KL[g]) && t < 1000) begin
      t++;
      if (printable_key(g, int'(key))) begin
        f = 1; k = int'(key);
        return;
      end
      key += KP[g];
    end
  endtask

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_u
    logic          core_rdy = 1'b1;
    logic [7:0]    pt_rddata;
    logic [7:0]    mem [256];
    logic [KW-1:0] lat_key = '0;
    int cnt = 0, n_en = 0, n_rd = 0, maxa = 0, viol = 0, gap = 0, ksum = 0;

    arc4_key_sweep #(.KEY_W(KW), .KEY_START(KW'(KS[g])), .KEY_STEP(KW'(KP[g])),
                     .KEY_LAST(KW'(KL[g]))) u_dut (
      .clk(clk), .rst(rst), .en(en[g]), .rdy(rdy_v[g]), .abort(abort[g]),
      .core_en(core_en_v[g]), .core_rdy(core_rdy), .core_key(core_key_v[g]),
      .pt_sel(pt_sel_v[g]), .pt_addr(pt_addr_v[g]), .pt_rddata(pt_rddata),
      .done(done_v[g]), .found(found_v[g]), .key_out(key_v[g]), .tries(tries_v[g]));

    always @(posedge clk) begin
      pt_rddata <= mem[pt_addr_v[g]];
      if (clr) begin
        n_en <= 0; n_rd <= 0; maxa <= 0; viol <= 0; gap <= 0; ksum <= 0;
      end else begin
        if (core_en_v[g]) begin
          n_en <= n_en + 1;
          ksum <= ksum + int'(core_key_v[g]);
          if (n_en == 0 && core_key_v[g] != KW'(KS[g])) gap <= gap + 1;
          if (n_en > 0 && core_key_v[g] != lat_key + KW'(KP[g])) gap <= gap + 1;
        end
        if (pt_sel_v[g] && pt_addr_v[g] != 8'd0) begin
          n_rd <= n_rd + 1;
          if (int'(pt_addr_v[g]) > maxa) maxa <= int'(pt_addr_v[g]);
        end
        if (!core_rdy && core_key_v[g] != lat_key) viol <= viol + 1;
      end
      if (core_en_v[g]) begin
        lat_key  <= core_key_v[g];
        core_rdy <= 1'b0;
        cnt      <= busy_len[g];
      end else if (!core_rdy) begin
        if (cnt == 0) begin
          core_rdy <= 1'b1;
          for (int a = 0; a < 256; a++) mem[a] <= gen(md[g], mt[g], sd[g], int'(lat_key), a);
        end else cnt <= cnt - 1;
      end
    end

    assign st_en[g] = n_en;
    assign st_rd[g] = n_rd;
    assign st_maxa[g] = maxa;
    assign st_viol[g] = viol;
    assign st_gap[g] = gap;
    assign st_ksum[g] = ksum;
  end

  task automatic start(input int g);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    en[g] = 1'b1; @(negedge clk); en[g] = 1'b0;
    chk("rdy_drop", rdy_v[g], 0);
  endtask

  task automatic wait_done(input int g);
    int cyc = 0;
    while (!done_v[g] && cyc < 20000) begin @(negedge clk); cyc++; end
    chk("done_timeout", cyc < 20000, 1);
  endtask

  task automatic run(input int g);
    bit ef; int ek, et;
    ref_run(g, ef, ek, et);
    start(g);
    wait_done(g);
    chk("found", found_v[g], ef);
    chk("key_out", key_v[g], ek);
    chk("tries", tries_v[g], et);
    chk("rdy_at_done", rdy_v[g], 1);
    chk("core_en_pulses", st_en[g], et);
    chk("key_sequence", st_gap[g], 0);
    chk("key_stable", st_viol[g], 0);
  endtask

  initial begin
    int r, cyc;
    for (int g = 0; g < N; g++) begin md[g] = 0; mt[g] = -1; sd[g] = 0; busy_len[g] = 2; end
    repeat (2) @(negedge clk);
    chk("rst_rdy", rdy_v[0], 1);        chk("rst_done", done_v[0], 0);
    chk("rst_found", found_v[0], 0);    chk("rst_key_out", key_v[0], 0);
    chk("rst_tries", tries_v[0], 0);    chk("rst_core_en", core_en_v[0], 0);
    chk("rst_pt_sel", pt_sel_v[0], 0);  chk("rst_pt_addr", pt_addr_v[0], 0);
    chk("rst_core_key_b", core_key_v[1], 1);
    rst = 1'b0;
    @(negedge clk);

    md[0] = 0; mt[0] = 3; sd[0] = 17; run(0);
    chk("hello_key", key_v[0], 3);  chk("hello_tries", tries_v[0], 4);

    md[1] = 0; mt[1] = 9; sd[1] = 5; run(1);
    chk("stride_ksum", st_ksum[1], 15);  chk("stride_key", key_v[1], 9);

    md[2] = 0; mt[2] = -1; sd[2] = 3; run(2);
    chk("exhaust_tries", tries_v[2], 8);
    repeat (20) @(negedge clk);
    chk("no_ninth_pulse", st_en[2], 8);

    md[0] = 1; run(0);
    chk("len0_reads", st_rd[0], 0);  chk("len0_pulses", st_en[0], 1);

    md[0] = 2; busy_len[0] = 0; run(0);
    chk("sweep_reads", st_rd[0], 256);  chk("sweep_max_addr", st_maxa[0], 255);
    chk("sweep_key", key_v[0], 1);

    for (int n = 0; n < 6; n++) begin
      int g;
      g = int'($urandom_range(0, 2));
      md[g] = 0; sd[g] = int'($urandom_range(0, 1000)); busy_len[g] = int'($urandom_range(0, 5));
      r = int'($urandom_range(0, 12));
      if (g == 0) mt[g] = r;
      else if (g == 1) mt[g] = (r % 4 == 3) ? -1 : 1 + 4 * (r % 4);
      else mt[g] = (r > 7) ? -1 : r;
      run(g);
    end

    // abort while the core is busy: must hold off DONE until the core returns
    md[0] = 0; mt[0] = 3; busy_len[0] = 12;
    start(0);
    cyc = 0;
    while (g_u[0].core_rdy && cyc < 100) begin @(negedge clk); cyc++; end
    chk("core_busy_seen", g_u[0].core_rdy, 0);
    @(negedge clk); @(negedge clk);
    abort[0] = 1'b1; @(negedge clk); abort[0] = 1'b0;
    @(negedge clk);
    chk("drain_not_done", done_v[0], 0);
    chk("drain_not_rdy", rdy_v[0], 0);
    wait_done(0);
    chk("drain_core_back", g_u[0].core_rdy, 1);
    chk("abort_found", found_v[0], 0);
    chk("abort_key_out", key_v[0], 0);

    // asynchronous reset in the middle of a byte scan
    md[0] = 2; busy_len[0] = 1;
    start(0);
    cyc = 0;
    while (!(pt_sel_v[0] && pt_addr_v[0] > 8'd10) && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("scan_reached", pt_addr_v[0] > 8'd10, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rdy", rdy_v[0], 1);        chk("mid_rst_done", done_v[0], 0);
    chk("mid_rst_pt_sel", pt_sel_v[0], 0);  chk("mid_rst_pt_addr", pt_addr_v[0], 0);
    chk("mid_rst_core_key", core_key_v[0], 0);
    chk("mid_rst_tries", tries_v[0], 0);    chk("mid_rst_found", found_v[0], 0);
    @(negedge clk); rst = 1'b0; @(negedge clk);

    md[0] = 0; mt[0] = 2; busy_len[0] = 3; run(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
